rxshift_param: RTL and testbench

Parametrised next-generation UART receive shifter. It replaces the fixed 8-bit rxshift.
- Oversamples i_Rx_Serial on an external baud tick from baudgen.
- Frame format: configurable data width, runtime-selectable parity and 1 or 2 stop bits.
- Reports parity, framing and overrun errors.
- Delivers each byte over a valid/ready handshake to the USRT register/FIFO layer.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/rx_sync.sv | 33 +++
 rtl/rxshift_param.sv | 183 ++++++++++++++++++
 tb/tb_rxshift_param.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM encoding, parity-mode constants and parity helper.
// Also intended for the planned txshift_param.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop1,
        StStop2
    } rx_state_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Callers zero-extend narrower words; zeros do not change the XOR.
    function automatic logic xor_reduce(input logic [15:0] i_word);
        return ^i_word;
    endfunction

endpackage

// File: rtl/rx_sync.sv
// Serial-line synchroniser with a tick-qualified falling-edge detect.
// Resets to line-idle high so reset never looks like a start bit.
module rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_Pclk,
    input  logic i_Reset,
    input  logic i_Bclk,
    input  logic i_Rx_Serial,
    output logic o_Rx,
    output logic o_Fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge i_Pclk or posedge i_Reset) begin
        if (i_Reset) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_Rx_Serial};
            // Previous value tracks the line at tick rate, so a held-low break cannot retrigger.
            if (i_Bclk) begin
                r_prev <= r_sync[SYNC_STAGES-1];
            end
        end
    end

    assign o_Rx   = r_sync[SYNC_STAGES-1];
    assign o_Fall = r_prev & ~r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/rxshift_param.sv
// Parametrised UART receive shifter with parity/framing/overrun reporting and valid/ready output.
// Define RXSHIFT_MAJORITY_EN for 2-of-3 majority bit sampling around mid-bit.
module rxshift_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 i_Pclk,
    input  logic                 i_Reset,
    input  logic                 i_Bclk,
    input  logic                 i_Enable,
    input  logic                 i_Rx_Serial,
    input  logic                 i_Parity_En,
    input  logic                 i_Parity_Odd,
    input  logic                 i_Stop2,
    output logic [DATA_BITS-1:0] o_Data,
    output logic                 o_Valid,
    input  logic                 i_Ready,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Overrun,
    output logic                 o_Busy
);

    localparam int CW  = $clog2(OVERSAMPLE);
    localparam int MID = OVERSAMPLE / 2 - 1;
    localparam logic [3:0]    BIT_LAST = 4'(DATA_BITS - 1);
    localparam logic [CW-1:0] BIT_DEC  = CW'(OVERSAMPLE - 1);

    rx_state_e r_state, w_state_next;
    logic [CW-1:0]        r_cnt;
    logic [3:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_en, r_par_odd, r_stop2;
    logic                 r_perr, r_ferr;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid, r_perr_out, r_ferr_out, r_overrun, r_busy;

    logic w_rx, w_fall, w_bit_val, w_start_dec, w_bit_dec, w_complete, w_accept, w_run;

    rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rx_sync (
        .i_Pclk     (i_Pclk),
        .i_Reset    (i_Reset),
        .i_Bclk     (i_Bclk),
        .i_Rx_Serial(i_Rx_Serial),
        .o_Rx       (w_rx),
        .o_Fall     (w_fall)
    );

`ifdef RXSHIFT_MAJORITY_EN
    // Decision moves to mid+1; the two earlier samples are held for the vote.
    localparam logic [CW-1:0] START_DEC = CW'(MID + 1);
    localparam logic [CW-1:0] START_A   = CW'(MID - 1);
    localparam logic [CW-1:0] START_B   = CW'(MID);
    localparam logic [CW-1:0] BIT_A     = CW'(OVERSAMPLE - 3);
    localparam logic [CW-1:0] BIT_B     = CW'(OVERSAMPLE - 2);
    logic r_maj_a, r_maj_b;

    always_ff @(posedge i_Pclk or posedge i_Reset) begin
        if (i_Reset) begin
            r_maj_a <= 1'b1;
            r_maj_b <= 1'b1;
        end else if (i_Bclk) begin
            if ((r_state == StStart) ? (r_cnt == START_A) : (r_cnt == BIT_A)) r_maj_a <= w_rx;
            if ((r_state == StStart) ? (r_cnt == START_B) : (r_cnt == BIT_B)) r_maj_b <= w_rx;
        end
    end

    assign w_bit_val = (r_maj_a & r_maj_b) | (r_maj_a & w_rx) | (r_maj_b & w_rx);
`else
    localparam logic [CW-1:0] START_DEC = CW'(MID);
    assign w_bit_val = w_rx;
`endif

    assign w_run       = i_Bclk & i_Enable;
    assign w_start_dec = (r_cnt == START_DEC);
    assign w_bit_dec   = (r_cnt == BIT_DEC);
    assign w_complete  = w_run & w_bit_dec &
                         (((r_state == StStop1) & ~r_stop2) | (r_state == StStop2));
    assign w_accept    = r_valid & i_Ready;

    always_ff @(posedge i_Pclk or posedge i_Reset) begin
        if (i_Reset) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != StIdle);
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (r_state != StIdle && !i_Enable) begin
            w_state_next = StIdle;
        end else if (i_Bclk) begin
            unique case (r_state)
                StIdle:   if (i_Enable && w_fall) w_state_next = StStart;
                StStart:  if (w_start_dec) w_state_next = w_bit_val ? StIdle : StData;
                StData:   if (w_bit_dec && r_bit_cnt == BIT_LAST)
                              w_state_next = r_par_en ? StParity : StStop1;
                StParity: if (w_bit_dec) w_state_next = StStop1;
                StStop1:  if (w_bit_dec) w_state_next = r_stop2 ? StStop2 : StIdle;
                StStop2:  if (w_bit_dec) w_state_next = StIdle;
                default:  w_state_next = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_Pclk or posedge i_Reset) begin
        if (i_Reset) begin
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par_en  <= 1'b0;
            r_par_odd <= 1'b0;
            r_stop2   <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
        end else if (w_run) begin
            if (r_state == StIdle) begin
                if (w_fall) begin
                    r_cnt     <= '0;
                    r_bit_cnt <= '0;
                    r_par_en  <= i_Parity_En;
                    r_par_odd <= i_Parity_Odd;
                    r_stop2   <= i_Stop2;
                    r_perr    <= 1'b0;
                    r_ferr    <= 1'b0;
                end
            end else if (r_state == StStart && w_start_dec) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == StData && w_bit_dec) begin
                r_shift   <= {w_bit_val, r_shift[DATA_BITS-1:1]};
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
            if (r_state == StParity && w_bit_dec) begin
                r_perr <= ((xor_reduce(16'(r_shift)) ^ w_bit_val) != r_par_odd);
            end
            if (r_state == StStop1 && w_bit_dec) begin
                r_ferr <= ~w_bit_val;
            end
        end
    end

    always_ff @(posedge i_Pclk or posedge i_Reset) begin
        if (i_Reset) begin
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_perr_out <= 1'b0;
            r_ferr_out <= 1'b0;
            r_overrun  <= 1'b0;
        end else if (w_complete) begin
            if (!r_valid || w_accept) begin
                r_data     <= r_shift;
                r_valid    <= 1'b1;
                r_perr_out <= r_perr;
                r_ferr_out <= r_ferr | ~w_bit_val;
                r_overrun  <= 1'b0;
            end else begin
                r_overrun <= 1'b1;
            end
        end else if (w_accept) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end
    end

    assign o_Data       = r_data;
    assign o_Valid      = r_valid;
    assign o_Parity_Err = r_perr_out;
    assign o_Frame_Err  = r_ferr_out;
    assign o_Overrun    = r_overrun;
    assign o_Busy       = r_busy;

endmodule

// File: tb/tb_rxshift_param.sv
// Directed bench for rxshift_param: an 8-bit and a 7-bit receiver share clock, tick and reset.
module tb_rxshift_param;
    import uart_pkg::*;

    localparam int BIT_T = 87;
`ifdef RXSHIFT_MAJORITY_EN
    localparam int HS_TICK = 153;
`else
    localparam int HS_TICK = 152;
`endif

    logic clk = 1'b0, rst = 1'b1, bclk = 1'b0;
    logic pen = 1'b0, podd = 1'b0, stop2 = 1'b0;
    logic en8 = 1'b0, rx8 = 1'b1, ready8 = 1'b0;
    logic en7 = 1'b0, rx7 = 1'b1, ready7 = 1'b0;
    logic [7:0] data8;
    logic [6:0] data7;
    logic valid8, perr8, ferr8, ovr8, busy8;
    logic valid7, perr7, ferr7, ovr7, busy7;
    int n_checks = 0, n_pass = 0, acc = 0;

    rxshift_param #(.DATA_BITS(8), .OVERSAMPLE(16), .SYNC_STAGES(2)) u_dut8 (
        .i_Pclk(clk), .i_Reset(rst), .i_Bclk(bclk), .i_Enable(en8), .i_Rx_Serial(rx8),
        .i_Parity_En(pen), .i_Parity_Odd(podd), .i_Stop2(stop2), .o_Data(data8),
        .o_Valid(valid8), .i_Ready(ready8), .o_Parity_Err(perr8), .o_Frame_Err(ferr8),
        .o_Overrun(ovr8), .o_Busy(busy8)
    );

    rxshift_param #(.DATA_BITS(7), .OVERSAMPLE(16), .SYNC_STAGES(2)) u_dut7 (
        .i_Pclk(clk), .i_Reset(rst), .i_Bclk(bclk), .i_Enable(en7), .i_Rx_Serial(rx7),
        .i_Parity_En(pen), .i_Parity_Odd(podd), .i_Stop2(stop2), .o_Data(data7),
        .o_Valid(valid7), .i_Ready(ready7), .o_Parity_Err(perr7), .o_Frame_Err(ferr7),
        .o_Overrun(ovr7), .o_Busy(busy7)
    );

    always #5 clk = ~clk;

    // 16 ticks per 87 clocks on average.
    always @(negedge clk) begin
        if (acc + 16 >= BIT_T) begin
            acc  = acc + 16 - BIT_T;
            bclk = 1'b1;
        end else begin
            acc  = acc + 16;
            bclk = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    endtask

    task automatic line_bit(input bit sel, input logic v);
        if (sel) rx7 = v;
        else rx8 = v;
        repeat (BIT_T) @(negedge clk);
    endtask

    task automatic send_frame(input bit sel, input int nbits, input logic [8:0] d,
                              input bit has_par, input logic pbit,
                              input int nstop, input logic s2val);
        line_bit(sel, 1'b0);
        for (int i = 0; i < nbits; i++) line_bit(sel, d[i]);
        if (has_par) line_bit(sel, pbit);
        line_bit(sel, 1'b1);
        if (nstop == 2) line_bit(sel, s2val);
        line_bit(sel, 1'b1);
        line_bit(sel, 1'b1);
    endtask

    task automatic accept8(input string tag);
        ready8 = 1'b1;
        @(posedge clk);
        #1;
        check(tag, {31'd0, valid8}, 32'd0);
        ready8 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic seen;
        int   k;
        int   w;
        logic [8:0] d55;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_data", {24'd0, data8}, 32'd0);
        check("rst_valid", {31'd0, valid8}, 32'd0);
        check("rst_errs", {29'd0, perr8, ferr8, ovr8}, 32'd0);
        check("rst_busy", {31'd0, busy8}, 32'd0);
        en8 = 1'b1;
        en7 = 1'b1;
        repeat (20) @(negedge clk);

        // 8N1
        send_frame(1'b0, 8, 9'h053, 1'b0, 1'b0, 1, 1'b1);
        check("8n1_data", {24'd0, data8}, 32'h53);
        check("8n1_valid", {31'd0, valid8}, 32'd1);
        check("8n1_errs", {29'd0, perr8, ferr8, ovr8}, 32'd0);
        check("8n1_busy", {31'd0, busy8}, 32'd0);
        accept8("8n1_accept");

        // 8E1: 0xA5 has even weight, so even parity bit is 0
        pen  = 1'b1;
        podd = PARITY_EVEN;
        send_frame(1'b0, 8, 9'h0A5, 1'b1, 1'b1, 1, 1'b1);
        check("8e1_bad_data", {24'd0, data8}, 32'hA5);
        check("8e1_bad_perr", {31'd0, perr8}, 32'd1);
        accept8("8e1_bad_accept");
        send_frame(1'b0, 8, 9'h0A5, 1'b1, 1'b0, 1, 1'b1);
        check("8e1_ok_valid", {31'd0, valid8}, 32'd1);
        check("8e1_ok_perr", {31'd0, perr8}, 32'd0);
        accept8("8e1_ok_accept");

        // 8N2 with second stop low, then clean
        pen   = 1'b0;
        stop2 = 1'b1;
        send_frame(1'b0, 8, 9'h096, 1'b0, 1'b0, 2, 1'b0);
        check("8n2_bad_ferr", {31'd0, ferr8}, 32'd1);
        check("8n2_bad_data", {24'd0, data8}, 32'h96);
        accept8("8n2_bad_accept");
        send_frame(1'b0, 8, 9'h03C, 1'b0, 1'b0, 2, 1'b1);
        check("8n2_ok_data", {24'd0, data8}, 32'h3C);
        check("8n2_ok_ferr", {31'd0, ferr8}, 32'd0);
        accept8("8n2_ok_accept");
        stop2 = 1'b0;

        // Short low glitch: false start
        seen = 1'b0;
        rx8  = 1'b0;
        repeat (16) begin @(negedge clk); seen |= busy8; end
        rx8 = 1'b1;
        repeat (150) begin @(negedge clk); seen |= busy8; end
        check("glitch_busy_seen", {31'd0, seen}, 32'd1);
        check("glitch_busy_end", {31'd0, busy8}, 32'd0);
        check("glitch_valid", {31'd0, valid8}, 32'd0);

        // Overrun
        send_frame(1'b0, 8, 9'h011, 1'b0, 1'b0, 1, 1'b1);
        send_frame(1'b0, 8, 9'h022, 1'b0, 1'b0, 1, 1'b1);
        check("ovr_data", {24'd0, data8}, 32'h11);
        check("ovr_flag", {31'd0, ovr8}, 32'd1);
        check("ovr_valid", {31'd0, valid8}, 32'd1);
        ready8 = 1'b1;
        @(posedge clk);
        #1;
        check("ovr_hs_valid", {31'd0, valid8}, 32'd0);
        check("ovr_hs_flag", {31'd0, ovr8}, 32'd0);
        ready8 = 1'b0;
        @(negedge clk);
        send_frame(1'b0, 8, 9'h033, 1'b0, 1'b0, 1, 1'b1);
        check("pre_hs_data", {24'd0, data8}, 32'h33);

        // Handshake on the completion edge of 0x44
        fork
            send_frame(1'b0, 8, 9'h044, 1'b0, 1'b0, 1, 1'b1);
            begin
                k = 0;
                w = 0;
                while (!busy8 && w < 400) begin @(negedge clk); w++; end
                check("hs_busy_rise", {31'd0, busy8}, 32'd1);
                for (int c = 0; c < 2000 && k < HS_TICK; c++) begin
                    #1;
                    if (bclk) k++;
                    if (k < HS_TICK) @(negedge clk);
                end
                check("hs_held_data", {24'd0, data8}, 32'h33);
                ready8 = 1'b1;
                @(posedge clk);
                #1;
                ready8 = 1'b0;
                check("hs_coin_data", {24'd0, data8}, 32'h44);
                check("hs_coin_valid", {31'd0, valid8}, 32'd1);
                check("hs_coin_ovr", {31'd0, ovr8}, 32'd0);
            end
        join
        accept8("hs_final_accept");

        // 7-bit receiver: enable dropped in bit 4
        d55 = 9'h055;
        line_bit(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) line_bit(1'b1, d55[i]);
        rx7 = d55[4];
        repeat (40) @(negedge clk);
        check("en_busy_before", {31'd0, busy7}, 32'd1);
        en7 = 1'b0;
        @(posedge clk);
        #1;
        check("en_busy_after", {31'd0, busy7}, 32'd0);
        rx7 = 1'b1;
        repeat (200) @(negedge clk);
        check("en_valid", {31'd0, valid7}, 32'd0);
        en7 = 1'b1;
        repeat (20) @(negedge clk);

        // Reset in bit 3
        line_bit(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) line_bit(1'b1, d55[i]);
        rx7 = d55[3];
        repeat (40) @(negedge clk);
        check("rst7_busy_before", {31'd0, busy7}, 32'd1);
        rst = 1'b1;
        rx7 = 1'b1;
        #1;
        check("rst7_outs", {24'd0, data7, valid7, perr7, ferr7, ovr7, busy7}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        send_frame(1'b1, 7, 9'h055, 1'b0, 1'b0, 1, 1'b1);
        check("7n1_data", {25'd0, data7}, 32'h55);
        check("7n1_valid", {31'd0, valid7}, 32'd1);
        check("7n1_errs", {29'd0, perr7, ferr7, ovr7}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
